// File: rtl/next_pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// next_pc_unit_pkg
// Definitions shared by the PC stage and the EX branch-decision logic:
// the 2-bit control-flow codes, the PC width and the sequential increment.
// Also provides a helper that word-aligns a target address.
// ---------------------------------------------------------------------------
package next_pc_unit_pkg;

    localparam int unsigned     PC_W   = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        BJ_SEQUENCE   = 2'b00,
        BJ_BRANCH     = 2'b01,
        BJ_NOT_BRANCH = 2'b10,
        BJ_JUMP       = 2'b11
    } bj_code_e;

    // Instructions are word aligned, so the two low address bits are dropped.
    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_unit_if.sv
// ---------------------------------------------------------------------------
// next_pc_unit_if
// Bundles the control-flow inputs from EX/hazard logic/instruction memory and
// the PC, flush and statistics outputs of the PC stage.
//   master : drives stall, imem_ready, branch_Or_Jump, branch_target,
//            jump_target; observes everything else
//   slave  : the PC stage itself (next_pc_unit)
// ---------------------------------------------------------------------------
interface next_pc_unit_if
    import next_pc_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);

    logic             stall;
    logic             imem_ready;
    logic [1:0]       branch_Or_Jump;
    logic [PC_W-1:0]  branch_target;
    logic [PC_W-1:0]  jump_target;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_plus4;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             redirect_pending;
    logic             target_misaligned;
    logic [CNT_W-1:0] branch_taken_cnt;
    logic [CNT_W-1:0] branch_not_taken_cnt;
    logic [CNT_W-1:0] jump_cnt;

    modport master (
        output stall, imem_ready, branch_Or_Jump, branch_target, jump_target,
        input  pc, pc_plus4, flush_if_id, flush_id_ex, redirect_pending,
               target_misaligned, branch_taken_cnt, branch_not_taken_cnt, jump_cnt
    );

    modport slave (
        input  stall, imem_ready, branch_Or_Jump, branch_target, jump_target,
        output pc, pc_plus4, flush_if_id, flush_id_ex, redirect_pending,
               target_misaligned, branch_taken_cnt, branch_not_taken_cnt, jump_cnt
    );

endinterface

// File: rtl/next_pc_unit_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// W-bit event counter that increments on every clock edge where i_inc is high
// and sticks at all-ones instead of wrapping.
//   clk     : clock
//   rst_n   : asynchronous active-low reset, clears the count
//   i_inc   : count this cycle
//   o_count : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/next_pc_unit.sv
// ---------------------------------------------------------------------------
// next_pc_unit
// Owns the fetch PC. Chooses between sequential, branch and jump next PC,
// holds on stalls or when instruction memory is busy, and buffers a redirect
// that arrives while memory is busy until it can be applied. Drives the
// IF/ID and ID/EX flushes and keeps saturating control-flow statistics.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : next_pc_unit_if.slave (control inputs, PC/flush/stat outputs)
// ---------------------------------------------------------------------------
module next_pc_unit
    import next_pc_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    next_pc_unit_if.slave bus
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_pending_target;
    logic            r_pending_valid;
    logic            r_misaligned;

    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pending_target_next;
    logic            w_pending_valid_next;
    logic            w_misaligned_next;

    logic            w_is_branch;
    logic            w_is_not_branch;
    logic            w_is_jump;
    logic            w_redir;
    logic [PC_W-1:0] w_raw_target;
    logic [PC_W-1:0] w_target;

    // Unknown codes cannot occur; the default arm treats them as Sequence.
    always_comb begin
        w_is_branch     = 1'b0;
        w_is_not_branch = 1'b0;
        w_is_jump       = 1'b0;
        case (bj_code_e'(bus.branch_Or_Jump))
            BJ_BRANCH:     w_is_branch     = 1'b1;
            BJ_NOT_BRANCH: w_is_not_branch = 1'b1;
            BJ_JUMP:       w_is_jump       = 1'b1;
            default:       ;
        endcase
    end

    assign w_redir      = w_is_branch | w_is_jump;
    assign w_raw_target = w_is_branch ? bus.branch_target : bus.jump_target;
    assign w_target     = align_word(w_raw_target);

    // A live redirect beats a buffered one (it is younger and overwrites it),
    // and both beat stall because the stalled instruction is being flushed.
    always_comb begin
        w_pc_next             = r_pc;
        w_pending_valid_next  = r_pending_valid;
        w_pending_target_next = r_pending_target;
        w_misaligned_next     = r_misaligned | (w_redir & (w_raw_target[1:0] != 2'b00));

        if (w_redir) begin
            if (bus.imem_ready) begin
                w_pc_next            = w_target;
                w_pending_valid_next = 1'b0;
            end else begin
                w_pending_valid_next  = 1'b1;
                w_pending_target_next = w_target;
            end
        end else if (r_pending_valid) begin
            if (bus.imem_ready) begin
                w_pc_next            = r_pending_target;
                w_pending_valid_next = 1'b0;
            end
        end else if (!bus.stall && bus.imem_ready) begin
            w_pc_next = r_pc + PC_INC;
        end
    end

    // PC, buffered redirect and sticky misalignment flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc             <= RESET_PC;
            r_pending_valid  <= 1'b0;
            r_pending_target <= '0;
            r_misaligned     <= 1'b0;
        end else begin
            r_pc             <= w_pc_next;
            r_pending_valid  <= w_pending_valid_next;
            r_pending_target <= w_pending_target_next;
            r_misaligned     <= w_misaligned_next;
        end
    end

    // IF/ID stays flushed while a buffered redirect waits, so no wrong-path
    // fetch slips through before the redirect lands.
    assign bus.pc                = r_pc;
    assign bus.pc_plus4          = r_pc + PC_INC;
    assign bus.flush_if_id       = w_redir | r_pending_valid;
    assign bus.flush_id_ex       = w_redir;
    assign bus.redirect_pending  = r_pending_valid;
    assign bus.target_misaligned = r_misaligned;

    // EX reports each code exactly once, so counting ignores stall/imem_ready.
    sat_counter #(.W(CNT_W)) u_branch_taken_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_is_branch),
        .o_count (bus.branch_taken_cnt)
    );

    sat_counter #(.W(CNT_W)) u_branch_not_taken_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_is_not_branch),
        .o_count (bus.branch_not_taken_cnt)
    );

    sat_counter #(.W(CNT_W)) u_jump_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_is_jump),
        .o_count (bus.jump_cnt)
    );

endmodule

// File: tb/tb_next_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_next_pc_unit
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the PC stage kept in this file. A small counter width
// is used so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_next_pc_unit;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;

    localparam logic [1:0] C_SEQ = 2'b00;
    localparam logic [1:0] C_BR  = 2'b01;
    localparam logic [1:0] C_NB  = 2'b10;
    localparam logic [1:0] C_JMP = 2'b11;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_ptgt;
    logic        m_pend;
    logic        m_mis;
    int          m_cb;
    int          m_cnb;
    int          m_cj;

    // Flush values sampled / predicted before the edge of the last cycle
    logic obs_fif;
    logic obs_fex;
    logic exp_fif;
    logic exp_fex;

    next_pc_unit_if #(.CNT_W(CNT_W)) bus ();

    next_pc_unit #(
        .RESET_PC (RST_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        bad = bad + 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic modelReset();
        m_pc   = RST_PC;
        m_ptgt = 32'h0;
        m_pend = 1'b0;
        m_mis  = 1'b0;
        m_cb   = 0;
        m_cnb  = 0;
        m_cj   = 0;
    endtask

    function automatic int satInc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    // Drives one cycle of inputs, samples flushes before the edge, advances
    // the model across the edge and returns 1 time unit after it.
    task automatic applyStimulus(input logic [1:0] code, input logic [31:0] bt,
                                 input logic [31:0] jt, input logic st, input logic rdy);
        logic        redir;
        logic [31:0] raw;
        logic [31:0] tgt;
        bus.branch_Or_Jump = code;
        bus.branch_target  = bt;
        bus.jump_target    = jt;
        bus.stall          = st;
        bus.imem_ready     = rdy;
        #1;
        redir   = (code == C_BR) || (code == C_JMP);
        raw     = (code == C_BR) ? bt : jt;
        tgt     = raw & 32'hFFFF_FFFC;
        exp_fif = redir || m_pend;
        exp_fex = redir;
        obs_fif = bus.flush_if_id;
        obs_fex = bus.flush_id_ex;
        @(posedge clk);
        if (redir && (raw[1:0] != 2'b00)) m_mis = 1'b1;
        if (code == C_BR)  m_cb  = satInc(m_cb);
        if (code == C_NB)  m_cnb = satInc(m_cnb);
        if (code == C_JMP) m_cj  = satInc(m_cj);
        if (redir) begin
            if (rdy) begin
                m_pc   = tgt;
                m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;
                m_ptgt = tgt;
            end
        end else if (m_pend) begin
            if (rdy) begin
                m_pc   = m_ptgt;
                m_pend = 1'b0;
            end
        end else if (!st && rdy) begin
            m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        modelReset();
        #2;
        total = total + 1;
        if (bus.pc !== RST_PC) begin
            $display("[TB] FAIL reset_pc: got %h want %h", bus.pc, RST_PC);
            bad = bad + 1;
        end
        total = total + 1;
        if (bus.pc_plus4 !== RST_PC + 32'd4) begin
            $display("[TB] FAIL reset_pc_plus4: got %h want %h", bus.pc_plus4, RST_PC + 32'd4);
            bad = bad + 1;
        end
        total = total + 1;
        if ({bus.redirect_pending, bus.target_misaligned} !== 2'b00) begin
            $display("[TB] FAIL reset_flags: got %b want 00", {bus.redirect_pending, bus.target_misaligned});
            bad = bad + 1;
        end
        total = total + 1;
        if ({bus.branch_taken_cnt, bus.branch_not_taken_cnt, bus.jump_cnt} !== '0) begin
            $display("[TB] FAIL reset_counters: got %h %h %h want 0", bus.branch_taken_cnt,
                     bus.branch_not_taken_cnt, bus.jump_cnt);
            bad = bad + 1;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] want;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
            want = 32'(i * 4);
            total = total + 1;
            if (bus.pc !== want) begin
                $display("[TB] FAIL seq_pc: got %h want %h", bus.pc, want);
                bad = bad + 1;
            end
            total = total + 1;
            if ({obs_fif, obs_fex} !== 2'b00) begin
                $display("[TB] FAIL seq_flush: got %b want 00", {obs_fif, obs_fex});
                bad = bad + 1;
            end
        end
        total = total + 1;
        if (bus.branch_taken_cnt !== '0 || bus.jump_cnt !== '0 || bus.branch_not_taken_cnt !== '0) begin
            $display("[TB] FAIL seq_counters: got %h %h %h want 0", bus.branch_taken_cnt,
                     bus.branch_not_taken_cnt, bus.jump_cnt);
            bad = bad + 1;
        end
    endtask

    task automatic test_branch();
        applyStimulus(C_BR, 32'h40, 32'hDEAD_0000, 1'b0, 1'b1);
        total = total + 1;
        if ({obs_fif, obs_fex} !== 2'b11) begin
            $display("[TB] FAIL br_flush: got %b want 11", {obs_fif, obs_fex});
            bad = bad + 1;
        end
        total = total + 1;
        if (bus.pc !== 32'h40) begin
            $display("[TB] FAIL br_pc: got %h want %h", bus.pc, 32'h40);
            bad = bad + 1;
        end
        total = total + 1;
        if (bus.branch_taken_cnt !== CNT_W'(1)) begin
            $display("[TB] FAIL br_cnt: got %0d want 1", bus.branch_taken_cnt);
            bad = bad + 1;
        end
    endtask

    task automatic test_jump_pending();
        applyStimulus(C_JMP, 32'hBEEF_0000, 32'h100, 1'b0, 1'b0);
        total = total + 1;
        if ({obs_fif, obs_fex} !== 2'b11) begin
            $display("[TB] FAIL jp_flush0: got %b want 11", {obs_fif, obs_fex});
            bad = bad + 1;
        end
        applyStimulus(C_SEQ, 32'h0, 32'h0, 1'b0, 1'b0);
        total = total + 1;
        if ({obs_fif, obs_fex} !== 2'b10) begin
            $display("[TB] FAIL jp_flush1: got %b want 10", {obs_fif, obs_fex});
            bad = bad + 1;
        end
        total = total + 1;
        if (bus.redirect_pending !== 1'b1 || bus.pc !== 32'h40) begin
            $display("[TB] FAIL jp_hold: got pend=%b pc=%h want pend=1 pc=%h",
                     bus.redirect_pending, bus.pc, 32'h40);
            bad = bad + 1;
        end
        applyStimulus(C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        total = total + 1;
        if (bus.pc !== 32'h100 || bus.redirect_pending !== 1'b0) begin
            $display("[TB] FAIL jp_land: got pc=%h pend=%b want pc=%h pend=0",
                     bus.pc, bus.redirect_pending, 32'h100);
            bad = bad + 1;
        end
        total = total + 1;
        if (bus.jump_cnt !== CNT_W'(1)) begin
            $display("[TB] FAIL jp_cnt: got %0d want 1", bus.jump_cnt);
            bad = bad + 1;
        end
    endtask

    task automatic test_stall_redirect();
        applyStimulus(C_BR, 32'h200, 32'h0, 1'b1, 1'b1);
        total = total + 1;
        if (bus.pc !== 32'h200) begin
            $display("[TB] FAIL stall_br_pc: got %h want %h", bus.pc, 32'h200);
            bad = bad + 1;
        end
        applyStimulus(C_SEQ, 32'h0, 32'h0, 1'b1, 1'b1);
        total = total + 1;
        if (bus.pc !== 32'h200) begin
            $display("[TB] FAIL stall_hold_pc: got %h want %h", bus.pc, 32'h200);
            bad = bad + 1;
        end
    endtask

    task automatic test_misaligned();
        applyStimulus(C_BR, 32'h43, 32'h0, 1'b0, 1'b1);
        total = total + 1;
        if (bus.pc !== 32'h40 || bus.target_misaligned !== 1'b1) begin
            $display("[TB] FAIL mis_set: got pc=%h flag=%b want pc=%h flag=1",
                     bus.pc, bus.target_misaligned, 32'h40);
            bad = bad + 1;
        end
        applyStimulus(C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        applyStimulus(C_BR, 32'h80, 32'h0, 1'b0, 1'b1);
        total = total + 1;
        if (bus.target_misaligned !== 1'b1 || bus.branch_taken_cnt !== CNT_W'(4)) begin
            $display("[TB] FAIL mis_sticky: got flag=%b cnt=%0d want flag=1 cnt=4",
                     bus.target_misaligned, bus.branch_taken_cnt);
            bad = bad + 1;
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
            applyStimulus(C_NB, 32'h0, 32'h0, 1'b0, 1'b1);
            total = total + 1;
            if ({obs_fif, obs_fex} !== 2'b00) begin
                $display("[TB] FAIL nb_flush: got %b want 00", {obs_fif, obs_fex});
                bad = bad + 1;
            end
        end
        total = total + 1;
        if (bus.branch_not_taken_cnt !== CNT_W'(CNT_MAX)) begin
            $display("[TB] FAIL nb_sat: got %0d want %0d", bus.branch_not_taken_cnt, CNT_MAX);
            bad = bad + 1;
        end
    endtask

    task automatic test_wrap();
        applyStimulus(C_JMP, 32'h0, 32'hFFFF_FFF8, 1'b0, 1'b1);
        applyStimulus(C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        total = total + 1;
        if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0) begin
            $display("[TB] FAIL wrap_top: got pc=%h plus4=%h want pc=fffffffc plus4=0",
                     bus.pc, bus.pc_plus4);
            bad = bad + 1;
        end
        applyStimulus(C_SEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        total = total + 1;
        if (bus.pc !== 32'h0) begin
            $display("[TB] FAIL wrap_zero: got %h want 0", bus.pc);
            bad = bad + 1;
        end
    endtask

    task automatic test_reset_mid_pending();
        applyStimulus(C_JMP, 32'h0, 32'h300, 1'b0, 1'b0);
        total = total + 1;
        if (bus.redirect_pending !== 1'b1) begin
            $display("[TB] FAIL rmp_pend: got %b want 1", bus.redirect_pending);
            bad = bad + 1;
        end
        bus.branch_Or_Jump = C_SEQ;
        bus.imem_ready     = 1'b1;
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        total = total + 1;
        if (bus.pc !== RST_PC || bus.redirect_pending !== 1'b0 || bus.target_misaligned !== 1'b0) begin
            $display("[TB] FAIL rmp_async: got pc=%h pend=%b flag=%b want pc=%h pend=0 flag=0",
                     bus.pc, bus.redirect_pending, bus.target_misaligned, RST_PC);
            bad = bad + 1;
        end
        total = total + 1;
        if ({bus.branch_taken_cnt, bus.branch_not_taken_cnt, bus.jump_cnt} !== '0) begin
            $display("[TB] FAIL rmp_counters: got %h %h %h want 0", bus.branch_taken_cnt,
                     bus.branch_not_taken_cnt, bus.jump_cnt);
            bad = bad + 1;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [1:0]  code;
        logic [31:0] bt;
        logic [31:0] jt;
        logic        st;
        logic        rdy;
        for (int i = 0; i < 400; i++) begin
            code = 2'($urandom_range(0, 3));
            bt   = $urandom;
            jt   = $urandom;
            if ($urandom_range(0, 7) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) jt[1:0] = 2'b00;
            st   = ($urandom_range(0, 3) == 0);
            rdy  = ($urandom_range(0, 2) != 0);
            applyStimulus(code, bt, jt, st, rdy);
            total = total + 1;
            if ({obs_fif, obs_fex} !== {exp_fif, exp_fex}) begin
                $display("[TB] FAIL rnd_flush: got %b want %b", {obs_fif, obs_fex}, {exp_fif, exp_fex});
                bad = bad + 1;
            end
            total = total + 1;
            if (bus.pc !== m_pc || bus.pc_plus4 !== m_pc + 32'd4) begin
                $display("[TB] FAIL rnd_pc: got %h/%h want %h/%h", bus.pc, bus.pc_plus4, m_pc, m_pc + 32'd4);
                bad = bad + 1;
            end
            total = total + 1;
            if (bus.redirect_pending !== m_pend || bus.target_misaligned !== m_mis) begin
                $display("[TB] FAIL rnd_flags: got pend=%b mis=%b want pend=%b mis=%b",
                         bus.redirect_pending, bus.target_misaligned, m_pend, m_mis);
                bad = bad + 1;
            end
            total = total + 1;
            if (bus.branch_taken_cnt !== CNT_W'(m_cb) || bus.branch_not_taken_cnt !== CNT_W'(m_cnb)
                || bus.jump_cnt !== CNT_W'(m_cj)) begin
                $display("[TB] FAIL rnd_counters: got %0d %0d %0d want %0d %0d %0d",
                         bus.branch_taken_cnt, bus.branch_not_taken_cnt, bus.jump_cnt, m_cb, m_cnb, m_cj);
                bad = bad + 1;
            end
        end
    endtask

    initial begin
        total              = 0;
        bad                = 0;
        rst_n              = 1'b0;
        bus.stall          = 1'b0;
        bus.imem_ready     = 1'b1;
        bus.branch_Or_Jump = C_SEQ;
        bus.branch_target  = 32'h0;
        bus.jump_target    = 32'h0;
        modelReset();
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_jump_pending();
        test_stall_redirect();
        test_misaligned();
        test_saturation();
        test_wrap();
        test_reset_mid_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
